// File: rtl/lif_tm_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron scheduler.
package lif_tm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STALL} fsm_t;

  function automatic int idw(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Unsigned add clamped to 2^w-1; w must be below 32.
  function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b, int w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/lif_spike_fifo.sv
// Spike-ID FIFO; full is taken from the registered count, so a pop never frees a slot for a same-cycle push.
module lif_spike_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          valid,
  input  logic          ready,
  output logic [DW-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign dout    = valid ? mem[rd_ptr] : '0;
  assign do_push = push && !full;
  assign do_pop  = valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lif_tm_scheduler.sv
// Leaky integrate-and-fire bank sharing one update path; one slot visited per cycle,
// spikes queued as neuron IDs with valid/ready back-pressure.
module lif_tm_scheduler import lif_tm_pkg::*; #(
  parameter int N_NEURONS    = 8,
  parameter int W            = 8,
  parameter int LEAK_SHIFT   = 1,
  parameter int THRESH_RESET = 127,
  parameter int FIFO_DEPTH   = 4,
  localparam int IDW         = idw(N_NEURONS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [W-1:0]   current,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_addr,
  input  logic [W-1:0]   cfg_thr,
  output logic           spk_valid,
  input  logic           spk_ready,
  output logic [IDW-1:0] spk_id,
  output logic [IDW-1:0] slot,
  output logic           busy,
  output logic           stall,
  output logic           epoch_done
);
  fsm_t         fsm;
  logic [W-1:0] mstate [N_NEURONS];
  logic [W-1:0] thr    [N_NEURONS];
  logic [W-1:0] shifted, sum;
  logic         upd, fire, fifo_full, blocked, push;

  // Threshold compare reads the pre-write value, so a same-cycle cfg write lands after this visit.
  assign shifted = mstate[slot] >> LEAK_SHIFT;
  assign sum     = W'(sat_add(32'(current), 32'(shifted), W));
  assign fire    = (sum >= thr[slot]);
  assign upd     = (fsm != IDLE);
  assign blocked = fire && fifo_full;
  assign push    = upd && fire && !fifo_full;

  lif_spike_fifo #(.DEPTH(FIFO_DEPTH), .DW(IDW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (slot),
    .full  (fifo_full),
    .valid (spk_valid),
    .ready (spk_ready),
    .dout  (spk_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      slot       <= '0;
      busy       <= 1'b0;
      stall      <= 1'b0;
      epoch_done <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mstate[i] <= '0;
        thr[i]    <= W'(THRESH_RESET);
      end
    end else begin
      epoch_done <= 1'b0;
      if (cfg_we) thr[cfg_addr] <= cfg_thr;
      case (fsm)
        IDLE: if (en) begin
          fsm  <= RUN;
          busy <= 1'b1;
        end
        RUN, STALL: begin
          if (blocked) begin
            fsm   <= STALL;
            stall <= 1'b1;
          end else begin
            mstate[slot] <= fire ? '0 : sum;
            stall        <= 1'b0;
            if (slot == IDW'(N_NEURONS - 1)) begin
              // en only matters at the wrap, so a dropped en still finishes the epoch.
              slot       <= '0;
              epoch_done <= 1'b1;
              if (en) fsm <= RUN;
              else begin
                fsm  <= IDLE;
                busy <= 1'b0;
              end
            end else begin
              slot <= slot + 1'b1;
              fsm  <= RUN;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_tm_scheduler.sv
// Randomised bench: a visit-level reference model feeds a spike scoreboard; control outputs compared each cycle.
module tb_lif_tm_scheduler;
  localparam int N   = 8;
  localparam int W   = 8;
  localparam int LS  = 1;
  localparam int TR  = 127;
  localparam int FD  = 4;
  localparam int IDW = 3;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst, en, cfg_we, spk_ready;
  logic [W-1:0]   current, cfg_thr;
  logic [IDW-1:0] cfg_addr;
  logic           spk_valid, busy, stall, epoch_done;
  logic [IDW-1:0] spk_id, slot;

  int errors = 0;
  int checks = 0;

  // reference model state
  int mst  [N];
  int mthr [N];
  int mq[$];
  int exp_q[$];
  int m_slot;
  bit m_run, m_stall, m_epoch;

  lif_tm_scheduler #(
    .N_NEURONS(N), .W(W), .LEAK_SHIFT(LS), .THRESH_RESET(TR), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .current(current),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_thr(cfg_thr),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_id(spk_id),
    .slot(slot), .busy(busy), .stall(stall), .epoch_done(epoch_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor pops the scoreboard on each DUT handshake; the model then advances one cycle.
  always @(posedge clk) begin
    int e, sum, id;
    bit full, pop, dopush, fire;
    if (!rst && spk_valid && spk_ready) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL spk_unexpected actual=%0d expected=none at %0t", spk_id, $time);
      end else begin
        e = exp_q.pop_front();
        chk("spk_id", int'(spk_id), e);
      end
    end
    if (rst) begin
      for (int i = 0; i < N; i++) begin mst[i] = 0; mthr[i] = TR; end
      mq.delete(); exp_q.delete();
      m_slot = 0; m_run = 0; m_stall = 0; m_epoch = 0;
    end else begin
      full   = (mq.size() == FD);
      pop    = (mq.size() > 0) && spk_ready;
      dopush = 0; id = 0;
      m_epoch = 0;
      if (!m_run) begin
        if (en) m_run = 1;
      end else begin
        sum = int'(current) + (mst[m_slot] >> LS);
        if (sum > MAXV) sum = MAXV;
        fire = (sum >= mthr[m_slot]);
        if (fire && full) m_stall = 1;
        else begin
          m_stall = 0;
          if (fire) begin mst[m_slot] = 0; dopush = 1; id = m_slot; end
          else mst[m_slot] = sum;
          if (m_slot == N - 1) begin
            m_slot = 0; m_epoch = 1;
            if (!en) m_run = 0;
          end else m_slot++;
        end
      end
      if (pop) void'(mq.pop_front());
      if (dopush) begin mq.push_back(id); exp_q.push_back(id); end
      if (cfg_we) mthr[cfg_addr] = int'(cfg_thr);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("slot", int'(slot), m_slot);
    chk("busy", int'(busy), int'(m_run));
    chk("stall", int'(stall), int'(m_stall));
    chk("epoch_done", int'(epoch_done), int'(m_epoch));
    chk("spk_valid", int'(spk_valid), int'(mq.size() > 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_spk_id", int'(spk_id), 0);
    chk("reset_spk_valid", int'(spk_valid), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 0; current = '0; cfg_we = 0; cfg_addr = '0; cfg_thr = '0; spk_ready = 0;
    @(negedge clk);

    // 1: constant drive, default thresholds
    do_reset();
    en = 1; current = 8'd64; spk_ready = 1;
    for (int c = 0; c < 8 * 8 + 12; c++) tick();

    // 2: saturation with max thresholds
    for (int i = 0; i < N; i++) begin
      cfg_we = 1; cfg_addr = IDW'(i); cfg_thr = 8'd255; tick();
    end
    cfg_we = 0; current = 8'd200;
    for (int c = 0; c < 40; c++) tick();

    // 3: back-pressure into STALL, then drain
    do_reset();
    en = 1; current = 8'd255; spk_ready = 0;
    for (int c = 0; c < 10; c++) tick();
    chk("bp_stall", int'(stall), 1);
    chk("bp_slot", int'(slot), 4);
    n = 3 + $urandom_range(0, 5);
    for (int c = 0; c < n; c++) tick();
    spk_ready = 1;
    for (int c = 0; c < 20; c++) tick();

    // 4: runtime config, including same-cycle writes to the visited slot
    do_reset();
    en = 1; current = 8'd16; spk_ready = 1;
    for (int c = 0; c < 11; c++) tick();
    cfg_we = 1; cfg_addr = 3'd2; cfg_thr = 8'd10; tick();
    cfg_we = 0;
    for (int c = 0; c < 20; c++) tick();
    for (int k = 0; k < 6; k++) begin
      cfg_we = 1; cfg_addr = IDW'(m_slot); cfg_thr = 8'($urandom_range(0, 40)); tick();
      cfg_we = 0;
      for (int c = 0; c < int'($urandom_range(1, 6)); c++) tick();
    end
    for (int c = 0; c < 30; c++) tick();

    // 5: stop mid-epoch and resume
    n = 0;
    while (m_slot != 3 && n < 20) begin tick(); n++; end
    chk("stop_reach_slot3", m_slot, 3);
    en = 0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("stop_idle", int'(busy), 0);
    for (int c = 0; c < 5; c++) tick();
    en = 1;
    for (int c = 0; c < 30; c++) tick();

    // 6: reset while stalled with a full FIFO
    do_reset();
    en = 1; current = 8'd255; spk_ready = 0;
    for (int c = 0; c < 8; c++) tick();
    chk("pre_rst_stall", int'(stall), 1);
    do_reset();
    chk("rst_stall", int'(stall), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_slot", int'(slot), 0);
    en = 1; current = 8'd64; spk_ready = 1;
    for (int c = 0; c < 70; c++) tick();

    // 7: random traffic
    for (int c = 0; c < 1500; c++) begin
      en        = ($urandom_range(0, 7) != 0);
      current   = 8'($urandom_range(0, 255));
      spk_ready = ($urandom_range(0, 2) != 0);
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_addr  = IDW'($urandom_range(0, N - 1));
      cfg_thr   = 8'($urandom_range(0, 255));
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; cfg_we = 0;

    // drain
    en = 0; spk_ready = 1; current = '0;
    n = 0;
    while ((busy || spk_valid) && n < 200) begin tick(); n++; end
    chk("drain_busy", int'(busy), 0);
    chk("drain_scoreboard", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
